store_merge: RTL and testbench

Store-path line merge unit between the execute/memory stage and the 128-bit data cache. It is the write-direction counterpart of the memory writeback select: it accepts a scalar (32- or 36-bit) or vector (128-bit) store with the same `line`/`w_type` encoding and performs a read-modify-write on the cache line. The result is a full 128-bit line written back. The pipeline stalls on `st_ready` while a store is in flight.

---
 rtl/store_merge.sv | 130 +++++++++++++
 tb/tb_store_merge.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_merge.sv
// Store-path line merge: read-modify-write of a 128-bit cache line for
// 32/36-bit scalar stores, direct line write for 128-bit vector stores.
module store_merge #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [1:0]        st_line,
    input  logic [1:0]        st_type,
    input  logic [127:0]      st_data,
    output logic              cache_rd_req,
    output logic [ADDR_W-1:0] cache_rd_addr,
    input  logic              cache_rd_valid,
    input  logic [127:0]      cache_rd_data,
    output logic              cache_wr_req,
    output logic [ADDR_W-1:0] cache_wr_addr,
    output logic [127:0]      cache_wr_data,
    input  logic              cache_wr_ack,
    output logic              done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;

    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_W32  = 2'b01;
    localparam logic [1:0] T_W36  = 2'b10;
    localparam logic [1:0] T_VEC  = 2'b11;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        line_q, line_d;
    logic [1:0]        type_q, type_d;
    logic [35:0]       sdata_q, sdata_d;
    logic [127:0]      wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic [127:0]      merged;

    // Splice the registered scalar into the line returned by the cache.
    always_comb begin
        merged = cache_rd_data;
        if (type_q == T_W32) begin
            case (line_q)
                2'b00:   merged[31:0]   = sdata_q[31:0];
                2'b01:   merged[63:32]  = sdata_q[31:0];
                2'b10:   merged[95:64]  = sdata_q[31:0];
                default: merged[127:96] = sdata_q[31:0];
            endcase
        end else if (type_q == T_W36) begin
            if (line_q[1]) begin
                merged[99:64] = sdata_q;
            end else begin
                merged[35:0] = sdata_q;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        line_d    = line_q;
        type_d    = type_q;
        sdata_d   = sdata_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Type 00 is consumed silently and leaves no trace.
                if (st_valid && st_type != T_NONE) begin
                    addr_d  = st_addr;
                    line_d  = st_line;
                    type_d  = st_type;
                    sdata_d = st_data[35:0];
                    if (st_type == T_VEC) begin
                        wr_data_d = st_data;
                        state_d   = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (cache_rd_valid) begin
                    wr_data_d = merged;
                    state_d   = S_WR;
                end
            end
            S_WR: begin
                if (cache_wr_ack) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            line_q    <= 2'b00;
            type_q    <= T_NONE;
            sdata_q   <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            line_q    <= line_d;
            type_q    <= type_d;
            sdata_q   <= sdata_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    assign st_ready      = (state_q == S_IDLE);
    assign cache_rd_req  = (state_q == S_RD);
    assign cache_wr_req  = (state_q == S_WR);
    assign cache_rd_addr = addr_q;
    assign cache_wr_addr = addr_q;
    assign cache_wr_data = wr_data_q;
    assign done          = done_q;

endmodule

// File: tb/tb_store_merge.sv
// Randomized and directed bench for store_merge against a
// mask-and-shift model of the line merge.
module tb_store_merge;

    logic         clk = 1'b0;
    logic         rst;
    logic         st_valid;
    logic         st_ready;
    logic [31:0]  st_addr;
    logic [1:0]   st_line;
    logic [1:0]   st_type;
    logic [127:0] st_data;
    logic         cache_rd_req;
    logic [31:0]  cache_rd_addr;
    logic         cache_rd_valid;
    logic [127:0] cache_rd_data;
    logic         cache_wr_req;
    logic [31:0]  cache_wr_addr;
    logic [127:0] cache_wr_data;
    logic         cache_wr_ack;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [127:0] last_wr;

    always #5 clk = ~clk;

    store_merge #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_line(st_line),
        .st_type(st_type), .st_data(st_data),
        .cache_rd_req(cache_rd_req), .cache_rd_addr(cache_rd_addr),
        .cache_rd_valid(cache_rd_valid), .cache_rd_data(cache_rd_data),
        .cache_wr_req(cache_wr_req), .cache_wr_addr(cache_wr_addr),
        .cache_wr_data(cache_wr_data), .cache_wr_ack(cache_wr_ack),
        .done(done)
    );

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] model(input logic [1:0] typ,
                                           input logic [1:0] line,
                                           input logic [127:0] rd,
                                           input logic [127:0] d);
        logic [127:0] m;
        logic [127:0] v;
        int sh;
        if (typ == 2'b11) return d;
        if (typ == 2'b01) begin
            sh = 32 * (2 * int'(line[1]) + int'(line[0]));
            m = {96'd0, 32'hFFFF_FFFF} << sh;
            v = {96'd0, d[31:0]} << sh;
        end else begin
            sh = 64 * int'(line[1]);
            m = {92'd0, 36'hF_FFFF_FFFF} << sh;
            v = {92'd0, d[35:0]} << sh;
        end
        return (rd & ~m) | v;
    endfunction

    task automatic check_reset_outs(input string tag);
        check({tag, "_ready"}, st_ready, 1);
        check({tag, "_done"}, done, 0);
        check({tag, "_rdreq"}, cache_rd_req, 0);
        check({tag, "_wrreq"}, cache_wr_req, 0);
        check({tag, "_rdaddr"}, cache_rd_addr, 0);
        check({tag, "_wraddr"}, cache_wr_addr, 0);
        check({tag, "_wrdata"}, cache_wr_data, 0);
    endtask

    // One store with rdd wait cycles before rd_valid and wrd before ack.
    task automatic do_store(input logic [1:0] typ, input logic [1:0] line,
                            input logic [31:0] addr, input logic [127:0] d,
                            input logic [127:0] rd, input int rdd,
                            input int wrd);
        logic [127:0] exp;
        exp = model(typ, line, rd, d);
        check("ready_pre", st_ready, 1);
        st_valid = 1'b1;
        st_type  = typ;
        st_line  = line;
        st_addr  = addr;
        st_data  = d;
        tick();
        st_valid = 1'b0;
        st_type  = 2'($urandom);
        st_line  = 2'($urandom);
        st_addr  = $urandom;
        st_data  = rnd128();
        if (typ == 2'b00) begin
            check("nop_ready", st_ready, 1);
            check("nop_rdreq", cache_rd_req, 0);
            check("nop_wrreq", cache_wr_req, 0);
            check("nop_done", done, 0);
            return;
        end
        if (typ != 2'b11) begin
            for (int i = 0; i <= rdd; i++) begin
                check("rd_req", cache_rd_req, 1);
                check("rd_addr", cache_rd_addr, addr);
                check("rd_wrreq", cache_wr_req, 0);
                check("rd_ready", st_ready, 0);
                check("rd_done", done, 0);
                cache_rd_valid = (i == rdd);
                cache_rd_data  = (i == rdd) ? rd : rnd128();
                cache_wr_ack   = 1'($urandom);
                tick();
            end
            cache_rd_valid = 1'b0;
            cache_wr_ack   = 1'b0;
        end
        for (int j = 0; j <= wrd; j++) begin
            check("wr_req", cache_wr_req, 1);
            check("wr_addr", cache_wr_addr, addr);
            check("wr_data", cache_wr_data, exp);
            check("wr_rdreq", cache_rd_req, 0);
            check("wr_ready", st_ready, 0);
            check("wr_done", done, 0);
            last_wr        = cache_wr_data;
            cache_rd_valid = 1'($urandom);
            cache_rd_data  = rnd128();
            cache_wr_ack   = (j == wrd);
            tick();
        end
        cache_wr_ack   = 1'b0;
        cache_rd_valid = 1'b0;
        check("done", done, 1);
        check("done_ready", st_ready, 1);
        check("done_wrreq", cache_wr_req, 0);
    endtask

    task automatic reset_mid(input bit in_wr);
        st_valid = 1'b1;
        st_type  = 2'b01;
        st_line  = 2'($urandom);
        st_addr  = $urandom | 32'h1;
        st_data  = rnd128();
        tick();
        st_valid = 1'b0;
        if (in_wr) begin
            cache_rd_valid = 1'b1;
            cache_rd_data  = rnd128();
            tick();
            cache_rd_valid = 1'b0;
            check("rstwr_pre", cache_wr_req, 1);
            cache_wr_ack = 1'b1;
        end else begin
            check("rstrd_pre", cache_rd_req, 1);
            cache_rd_valid = 1'b1;
        end
        rst = 1'b1;
        tick();
        rst            = 1'b0;
        cache_wr_ack   = 1'b0;
        cache_rd_valid = 1'b0;
        check_reset_outs(in_wr ? "rstwr" : "rstrd");
        tick();
        check("rst_post_done", done, 0);
        check("rst_post_wrreq", cache_wr_req, 0);
    endtask

    initial begin
        rst            = 1'b1;
        st_valid       = 1'b1;
        st_type        = 2'b11;
        st_line        = 2'b00;
        st_addr        = 32'hCAFE_0000;
        st_data        = rnd128();
        cache_rd_valid = 1'b0;
        cache_rd_data  = '0;
        cache_wr_ack   = 1'b0;
        last_wr        = '0;
        tick();
        tick();
        tick();
        check_reset_outs("reset");
        rst = 1'b0;

        do_store(2'b01, 2'b10, 32'h100, 128'hDEAD_BEEF,
                 {16{8'h11}}, 0, 0);
        check("dir32", last_wr,
              128'h11111111_DEADBEEF_11111111_11111111);

        do_store(2'b10, 2'b01, 32'h200, 128'hA_BCDE_F012,
                 {128{1'b1}}, 0, 0);
        check("dir36", last_wr,
              {64'hFFFF_FFFF_FFFF_FFFF, 28'hFFF_FFFF, 36'hA_BCDE_F012});

        do_store(2'b11, 2'b00, 32'h300,
                 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                 rnd128(), 0, 0);
        check("dirvec", last_wr,
              128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);

        do_store(2'b01, 2'b11, 32'h400, rnd128(), rnd128(), 4, 3);
        do_store(2'b00, 2'b00, 32'h500, rnd128(), rnd128(), 0, 0);

        reset_mid(1'b0);
        reset_mid(1'b1);

        for (int k = 0; k < 60; k++) begin
            do_store(2'($urandom), 2'($urandom), $urandom, rnd128(),
                     rnd128(), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
